// File: rtl/password_pkg.sv
// Shared types and constants for the switch-driven password lock.
// Holds the controller state enum, digit/switch widths and small helpers.
package password_pkg;

  localparam int DIGIT_W = 4;
  localparam int NUM_SW  = 10;
  localparam logic [DIGIT_W-1:0] INVALID_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    ENTRY,
    UNLOCK,
    FAIL,
    LOCKOUT
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Digit idx of a code whose first digit sits in the most significant nibble.
  function automatic logic [DIGIT_W-1:0] nibble_at(input logic [31:0] code,
                                                   input int len, input int idx);
    return DIGIT_W'(code >> (DIGIT_W * (len - 1 - idx)));
  endfunction

endpackage

// File: rtl/password_entry_ctrl_if.sv
// Switch input and status/display outputs of the password entry controller.
// master drives the switches and observes status; slave is the controller.
interface password_entry_ctrl_if;
  import password_pkg::*;

  logic [NUM_SW-1:0]  switches;
  logic               digit_valid;
  logic [DIGIT_W-1:0] entered_digit;
  logic [3:0]         digit_count;
  logic               unlocked;
  logic               fail_pulse;
  logic [1:0]         attempts_left;
  logic               locked_out;

  modport master (
    output switches,
    input  digit_valid, entered_digit, digit_count, unlocked,
    input  fail_pulse, attempts_left, locked_out
  );

  modport slave (
    input  switches,
    output digit_valid, entered_digit, digit_count, unlocked,
    output fail_pulse, attempts_left, locked_out
  );

endinterface

// File: rtl/password_entry_ctrl_switch_press_detect.sv
// Turns rising switch edges into press events with a decoded digit.
// Several switches rising in the same cycle form one invalid press.
module switch_press_detect
  import password_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SW-1:0]  switches,
  output logic               press,
  output logic [DIGIT_W-1:0] digit,
  output logic               invalid
);

  logic [NUM_SW-1:0] sw_q;
  logic [NUM_SW-1:0] rise;

  // NOTE: registers use non-blocking assignments; reset is synchronous, so it lives inside the clocked block.
  // sw_q resets to all ones so switches already up at reset release raise no event.
  always_ff @(posedge clk) begin
    if (rst) sw_q <= '1;
    else     sw_q <= switches;
  end

  // NOTE: every output of this block gets a default before any condition, so no latch is inferred.
  always_comb begin
    rise    = switches & ~sw_q;
    press   = |rise;
    invalid = (rise & (rise - NUM_SW'(1))) != '0;
    digit   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (rise[i]) digit = DIGIT_W'(i);
    end
  end

endmodule

// File: rtl/password_entry_ctrl.sv
// Password entry FSM: collects CODE_LEN digits, unlocks or counts failures, times lockout.
// Define PASSWORD_TIMEOUT_EN to abandon a partial entry after TIMEOUT_CYCLES idle clocks.
module password_entry_ctrl
  import password_pkg::*;
#(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   PASSWORD       = 16'h3715,
  parameter int                      MAX_FAIL       = 3,
  parameter int                      UNLOCK_CYCLES  = 100,
  parameter int                      LOCK_CYCLES    = 1000,
  parameter int                      TIMEOUT_CYCLES = 500
) (
  input logic                  clk,
  input logic                  rst,
  password_entry_ctrl_if.slave bus
);

  localparam int TMAX    = max3(UNLOCK_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic               press;
  logic               invalid;
  logic [DIGIT_W-1:0] digit;

  switch_press_detect u_detect (
    .clk      (clk),
    .rst      (rst),
    .switches (bus.switches),
    .press    (press),
    .digit    (digit),
    .invalid  (invalid)
  );

  state_e             state;
  logic [TIMER_W-1:0] timer;
  logic               mismatch;
  logic [3:0]         digit_count;
  logic [DIGIT_W-1:0] entered_digit;
  logic               digit_valid;
  logic               unlocked;
  logic               fail_pulse;
  logic               locked_out;
  logic [1:0]         attempts_left;

  logic wrong;
  logic last_digit;

  always_comb begin
    wrong      = invalid || (digit != nibble_at(32'(PASSWORD), CODE_LEN, int'(digit_count)));
    last_digit = (digit_count == 4'(CODE_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ENTRY;
      timer         <= '0;
      mismatch      <= 1'b0;
      digit_count   <= '0;
      entered_digit <= '0;
      digit_valid   <= 1'b0;
      unlocked      <= 1'b0;
      fail_pulse    <= 1'b0;
      locked_out    <= 1'b0;
      attempts_left <= 2'(MAX_FAIL);
    end else begin
      digit_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (press) begin
            digit_valid   <= 1'b1;
            entered_digit <= invalid ? INVALID_DIGIT : digit;
            timer         <= '0;
            if (last_digit) begin
              // The full count is shown alongside the last pulse, then cleared by the next state.
              digit_count <= 4'(CODE_LEN);
              mismatch    <= 1'b0;
              if (mismatch || wrong) begin
                state         <= FAIL;
                fail_pulse    <= 1'b1;
                attempts_left <= attempts_left - 2'd1;
              end else begin
                state         <= UNLOCK;
                unlocked      <= 1'b1;
                attempts_left <= 2'(MAX_FAIL);
              end
            end else begin
              digit_count <= digit_count + 4'd1;
              mismatch    <= mismatch | wrong;
            end
          end
`ifdef PASSWORD_TIMEOUT_EN
          else if (digit_count != '0) begin
            if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
              digit_count <= '0;
              mismatch    <= 1'b0;
              timer       <= '0;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
`endif
        end

        UNLOCK: begin
          digit_count <= '0;
          if (timer == TIMER_W'(UNLOCK_CYCLES - 1)) begin
            unlocked <= 1'b0;
            state    <= ENTRY;
            timer    <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        FAIL: begin
          fail_pulse  <= 1'b0;
          digit_count <= '0;
          timer       <= '0;
          if (attempts_left == 2'd0) begin
            state      <= LOCKOUT;
            locked_out <= 1'b1;
          end else begin
            state <= ENTRY;
          end
        end

        LOCKOUT: begin
          digit_count <= '0;
          if (timer == TIMER_W'(LOCK_CYCLES - 1)) begin
            locked_out    <= 1'b0;
            attempts_left <= 2'(MAX_FAIL);
            state         <= ENTRY;
            timer         <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        default: state <= ENTRY;
      endcase
    end
  end

  assign bus.digit_valid   = digit_valid;
  assign bus.entered_digit = entered_digit;
  assign bus.digit_count   = digit_count;
  assign bus.unlocked      = unlocked;
  assign bus.fail_pulse    = fail_pulse;
  assign bus.attempts_left = attempts_left;
  assign bus.locked_out    = locked_out;

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Self-checking bench for password_entry_ctrl: directed and randomized codes
// judged against an attempt-level model of the lock rules.
module tb_password_entry_ctrl;
  import password_pkg::*;

  localparam int              CODE_LEN = 4;
  localparam logic [15:0]     PASSWORD = 16'h3715;
  localparam int              MAX_FAIL = 3;
  localparam int              UNLOCK_N = 8;
  localparam int              LOCK_N   = 20;
  localparam int              TIMEOUT_N = 12;

  typedef logic [NUM_SW-1:0] mask_t;

  logic clk = 1'b0;
  logic rst;

  password_entry_ctrl_if bus ();

  password_entry_ctrl #(
    .CODE_LEN       (CODE_LEN),
    .PASSWORD       (PASSWORD),
    .MAX_FAIL       (MAX_FAIL),
    .UNLOCK_CYCLES  (UNLOCK_N),
    .LOCK_CYCLES    (LOCK_N),
    .TIMEOUT_CYCLES (TIMEOUT_N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pw[CODE_LEN] = '{3, 7, 1, 5};
  int model_attempts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_digit(input mask_t m);
    int cnt = 0;
    int idx = 0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (m[i]) begin
        cnt++;
        idx = i;
      end
    end
    return (cnt == 1) ? idx : 15;
  endfunction

  function automatic mask_t onehot(input int d);
    mask_t m;
    m = '0;
    m[d] = 1'b1;
    return m;
  endfunction

  // One non-final press: high two cycles, low two cycles.
  task automatic press_digit(input mask_t m, input int idx);
    bus.switches = m;
    tick();
    check("press_valid", bus.digit_valid, 1);
    check("press_count", bus.digit_count, idx + 1);
    check("press_digit", bus.entered_digit, exp_digit(m));
    tick();
    check("hold_no_repeat", bus.digit_valid, 0);
    bus.switches = '0;
    tick();
    tick();
  endtask

  task automatic run_code(input mask_t masks[CODE_LEN], input int start);
    bit match;
    bit saw_dv;
    int n;
    match = 1'b1;
    for (int i = 0; i < CODE_LEN; i++)
      if (masks[i] != onehot(pw[i])) match = 1'b0;
    for (int i = start; i < CODE_LEN - 1; i++) press_digit(masks[i], i);

    bus.switches = masks[CODE_LEN-1];
    tick();
    check("final_valid", bus.digit_valid, 1);
    check("final_count", bus.digit_count, CODE_LEN);
    check("final_digit", bus.entered_digit, exp_digit(masks[CODE_LEN-1]));
    if (match) begin
      check("unlock_rise", bus.unlocked, 1);
      check("unlock_no_fail", bus.fail_pulse, 0);
      model_attempts = MAX_FAIL;
      check("unlock_attempts", bus.attempts_left, model_attempts);
      n = 0;
      while (bus.unlocked === 1'b1 && n < 100) begin
        n++;
        if (n == 2) bus.switches = '0;
        tick();
      end
      bus.switches = '0;
      check("unlock_len", n, UNLOCK_N);
      check("unlock_count_clr", bus.digit_count, 0);
    end else begin
      check("fail_rise", bus.fail_pulse, 1);
      check("fail_no_unlock", bus.unlocked, 0);
      model_attempts--;
      check("fail_attempts", bus.attempts_left, model_attempts);
      tick();
      bus.switches = '0;
      check("fail_one_cycle", bus.fail_pulse, 0);
      check("fail_count_clr", bus.digit_count, 0);
      if (model_attempts == 0) begin
        check("lock_rise", bus.locked_out, 1);
        n = 0;
        saw_dv = 1'b0;
        while (bus.locked_out === 1'b1 && n < 200) begin
          n++;
          if (n == 3) bus.switches = onehot(3);
          if (n == 5) bus.switches = '0;
          if (bus.digit_valid !== 1'b0) saw_dv = 1'b1;
          tick();
        end
        check("lock_len", n, LOCK_N);
        check("lock_press_ignored", saw_dv, 0);
        model_attempts = MAX_FAIL;
        check("lock_attempts_reload", bus.attempts_left, model_attempts);
      end else begin
        check("fail_not_locked", bus.locked_out, 0);
      end
      tick();
      tick();
    end
  endtask

  mask_t good[CODE_LEN];
  mask_t bad[CODE_LEN];
  mask_t rnd[CODE_LEN];

  initial begin
    for (int i = 0; i < CODE_LEN; i++) good[i] = onehot(pw[i]);
    bad = good;
    bad[CODE_LEN-1] = onehot(4);
    model_attempts = MAX_FAIL;

    // Reset with a switch already high.
    rst = 1'b1;
    bus.switches = onehot(4);
    tick();
    tick();
    check("rst_valid", bus.digit_valid, 0);
    check("rst_count", bus.digit_count, 0);
    check("rst_digit", bus.entered_digit, 0);
    check("rst_unlocked", bus.unlocked, 0);
    check("rst_fail", bus.fail_pulse, 0);
    check("rst_locked", bus.locked_out, 0);
    check("rst_attempts", bus.attempts_left, MAX_FAIL);
    rst = 1'b0;
    tick();
    check("held_at_release", bus.digit_valid, 0);
    bus.switches = '0;
    tick();

    run_code(good, 0);
    run_code(bad, 0);
    run_code(good, 0);

    // Lockout, then recovery.
    for (int k = 0; k < MAX_FAIL; k++) run_code(bad, 0);
    run_code(good, 0);

    // Invalid press: 3 and 7 together as the first digit.
    rnd = good;
    rnd[0] = onehot(3) | onehot(7);
    rnd[1] = onehot(7);
    run_code(rnd, 0);

    // Reset mid-entry with switch 1 held.
    press_digit(good[0], 0);
    press_digit(good[1], 1);
    rst = 1'b1;
    bus.switches = onehot(1);
    tick();
    model_attempts = MAX_FAIL;
    check("midrst_count", bus.digit_count, 0);
    check("midrst_attempts", bus.attempts_left, model_attempts);
    rst = 1'b0;
    tick();
    check("midrst_held_valid", bus.digit_valid, 0);
    check("midrst_held_count", bus.digit_count, 0);
    bus.switches = '0;
    tick();

`ifdef PASSWORD_TIMEOUT_EN
    press_digit(good[0], 0);
    press_digit(good[1], 1);
    repeat (TIMEOUT_N - 4) begin
      check("to_no_fail", bus.fail_pulse, 0);
      tick();
    end
    check("to_before", bus.digit_count, 2);
    tick();
    check("to_cleared", bus.digit_count, 0);
    check("to_attempts", bus.attempts_left, model_attempts);
    check("to_no_fail_end", bus.fail_pulse, 0);
    run_code(good, 0);
`else
    press_digit(good[0], 0);
    press_digit(good[1], 1);
    repeat (30) tick();
    check("hold_partial", bus.digit_count, 2);
    run_code(good, 2);
`endif

    // Randomized attempts.
    for (int t = 0; t < 8; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      rnd = good;
      if (kind == 1) begin
        for (int i = 0; i < CODE_LEN; i++) rnd[i] = onehot(int'($urandom_range(0, 9)));
      end else if (kind == 2) begin
        int pos;
        int a;
        int b;
        pos = int'($urandom_range(0, CODE_LEN - 1));
        a = int'($urandom_range(0, 9));
        b = (a + 1 + int'($urandom_range(0, 8))) % 10;
        rnd[pos] = onehot(a) | onehot(b);
      end
      run_code(rnd, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/password_entry_ctrl.md
# password_entry_ctrl

Sequencing controller for the switch-driven password lock. Turns the ten slide switches into single digit-press events and collects a fixed-length code. Compares the code against a parameterised password and manages the unlock window, failed-attempt counting and a timed lockout. Its outputs feed the HEX display decoders and the status LEDs in the top-level password design.

## Interface
- `CODE_LEN`, 4: digits per attempt (1–8).
- `PASSWORD`, 16'h3715: expected digits, 4 bits each; first digit in the MSB nibble; width `4*CODE_LEN`.
- `MAX_FAIL`, 3: consecutive failures before lockout (1–3).
- `UNLOCK_CYCLES`, 100: length of the unlocked window in clocks.
- `LOCK_CYCLES`, 1000: length of the lockout in clocks.
- `TIMEOUT_CYCLES`, 500: idle limit for a partial entry (used only with `PASSWORD_TIMEOUT_EN`).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `switches` in 10: slide switches, already synchronised to `clk`; switch *i* means digit *i*.
- `digit_valid` out 1: one-cycle pulse per accepted press.
- `entered_digit` out 4: last accepted digit (0–9); 4'hF for an invalid multi-switch press.
- `digit_count` out 4: digits collected in the current attempt.
- `unlocked` out 1: high during the unlock window.
- `fail_pulse` out 1: one-cycle pulse on a wrong code.
- `attempts_left` out 2: remaining attempts before lockout.
- `locked_out` out 1: high during lockout (alarm LED).

## Operation
- **Edge detection**
  - `sw_q` holds the previous `switches` value; `rise = switches & ~sw_q`.
  - `sw_q` updates every cycle in every state, so a switch held through a state change never produces a late event.
- **Press event**
  - A press occurs when `rise != 0`.
  - Exactly one bit set: digit = bit index.
  - More than one bit set: the press is invalid, `entered_digit` = 4'hF, and the attempt is marked as mismatched.
- **FSM states:** ENTRY, UNLOCK, FAIL, LOCKOUT.
- **ENTRY**
  - On each press: `digit_count` += 1 and `digit_valid` pulses.
  - A sticky mismatch flag sets if the digit differs from the nibble at position `digit_count` of `PASSWORD`.
  - On the press that makes `digit_count == CODE_LEN`:
    - Mismatch is checked including the current digit.
    - Match: go to UNLOCK, `attempts_left` reloads to `MAX_FAIL`.
    - Mismatch: go to FAIL.
    - In both cases `digit_count` and the mismatch flag clear.
- **UNLOCK**
  - `unlocked` = 1 for exactly `UNLOCK_CYCLES` cycles, then return to ENTRY.
  - Presses are ignored: no `digit_valid`, no count.
- **FAIL**
  - Lasts one cycle; `fail_pulse` = 1 and `attempts_left` -= 1.
  - Next state is LOCKOUT if the new `attempts_left` is 0, otherwise ENTRY.
- **LOCKOUT**
  - `locked_out` = 1 for exactly `LOCK_CYCLES` cycles.
  - Presses are ignored.
  - On exit: go to ENTRY with `attempts_left` = `MAX_FAIL`.
- **Counters**
  - The cycle timer is sized with `$clog2` of the largest cycle parameter.
  - The timer resets on every state entry and never wraps.

## Timing
- All outputs are registered.
- **Reset values**
  - State ENTRY; `digit_count` 0; `entered_digit` 0.
  - `digit_valid`, `unlocked`, `fail_pulse`, `locked_out` all 0.
  - `attempts_left` = `MAX_FAIL`.
  - `sw_q` = all ones, so switches already high at reset release give no event.
- **Press latency:** a switch first sampled high at edge E gives `digit_valid` = 1 and updated `digit_count`/`entered_digit` after edge E, for one cycle.
- **Unlock timing:** on the final correct press at edge E, `unlocked` rises after E and falls after edge E+`UNLOCK_CYCLES`.
- **Fail timing:** on the final wrong press at edge E, `fail_pulse` is high in cycle E+1.
- **Lockout timing:** `locked_out` rises after edge E+1 and stays high for `LOCK_CYCLES` cycles.
- **Reset mid-operation:** `rst` sampled high at any edge returns every register to its reset value in that cycle, including mid-entry, mid-unlock and mid-lockout.

## Configuration
- **`PASSWORD_TIMEOUT_EN` defined**
  - In ENTRY with `digit_count > 0`, an idle counter runs and clears on each press.
  - Reaching `TIMEOUT_CYCLES` clears `digit_count` and the mismatch flag.
  - No `fail_pulse` is issued and `attempts_left` is unchanged.
- **Undefined:** a partial entry is held indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- **Package `password_pkg`:** state enum (ENTRY, UNLOCK, FAIL, LOCKOUT), `DIGIT_W` = 4, `NUM_SW` = 10, `INVALID_DIGIT` = 4'hF.
- **Sub-module `switch_press_detect`**
  - Owns `sw_q` and the rise logic.
  - Outputs `press`, `digit[3:0]` and `invalid`.
  - The controller FSM, timer and attempt counter stay in `password_entry_ctrl`.

## Test plan
Bench parameters: `UNLOCK_CYCLES`=8, `LOCK_CYCLES`=20, `TIMEOUT_CYCLES`=12.
- **Correct code:** pulse switches 3, 7, 1, 5, each high 2 cycles and low 2 cycles → four `digit_valid` pulses with `digit_count` 1..4, then `unlocked` = 1 for exactly 8 cycles; `attempts_left` = 3.
- **Wrong code:** enter 3, 7, 1, 4 → one-cycle `fail_pulse`, `attempts_left` 3→2, `digit_count` 0; then enter 3, 7, 1, 5 → unlock and `attempts_left` = 3.
- **Lockout:** three wrong codes → `locked_out` for 20 cycles; a press of switch 3 during lockout gives no `digit_valid`; afterwards `attempts_left` = 3 and a correct code unlocks.
- **Invalid press:** raise switches 3 and 7 in the same cycle → `entered_digit` = 4'hF and `digit_count` = 1; completing with 7, 1, 5 → `fail_pulse`.
- **Reset mid-entry:** enter 3, 7, assert `rst` for 1 cycle with switch 1 held high → `digit_count` 0, no event from the held switch, `attempts_left` = 3.
- **Timeout (`PASSWORD_TIMEOUT_EN` defined):** enter 3, 7, idle 12 cycles → `digit_count` 0, no `fail_pulse`.
